// File: rtl/relay_pkg.sv
// Shared types and constants for the relay sequencer: FSM state encoding,
// default timer width and the switch-counter width.
package relay_pkg;

  localparam int CNT_W_DEF    = 32;
  localparam int SWITCH_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ON_MIN  = 3'd1,
    ST_ON      = 3'd2,
    ST_OFF_MIN = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SWITCH_CNT_W-1:0] sat_inc(input logic [SWITCH_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/relay_debounce.sv
// Two-flop synchroniser followed by a stability counter: the output only
// follows the input after DEB_CYCLES consecutive cycles of disagreement.
module relay_debounce
  import relay_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEB_CYCLES = CNT_W'(1_000_000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] DEB_LAST = DEB_CYCLES - CNT_W'(1);

  logic [1:0]       sync_q;
  logic             req_s;
  logic             req_db_q, req_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign req_s = sync_q[1];

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      req_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], din};
      req_db_q <= req_db_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    req_db_d = req_db_q;
    cnt_d    = '0;
    if (req_s != req_db_q) begin
      if (cnt_q == DEB_LAST) begin
        req_db_d = req_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign dout = req_db_q;

endmodule

// File: rtl/relay_sequencer.sv
// Debounced, rate-limited relay command with minimum on/off times.
// Define RELAY_MAX_ON_EN to add a maximum on-time with fault lockout.
module relay_sequencer
  import relay_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEB_CYCLES = CNT_W'(1_000_000),
  parameter logic [CNT_W-1:0] MIN_ON     = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] MIN_OFF    = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] MAX_ON     = CNT_W'(32'd3_000_000_000)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_in,
  output logic                    relay_control,
  output logic                    led_output,
  output logic                    fault,
  output logic [SWITCH_CNT_W-1:0] switch_count,
  output logic [2:0]              state_o
);

  localparam logic [CNT_W-1:0] MIN_ON_LAST  = MIN_ON - CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_OFF_LAST = MIN_OFF - CNT_W'(1);

  logic                    req_db;
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic [SWITCH_CNT_W-1:0] switch_count_q, switch_count_d;
  logic                    relay_q, relay_d;

  relay_debounce #(
    .CNT_W      (CNT_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (req_in),
    .dout  (req_db)
  );

`ifdef RELAY_MAX_ON_EN
  localparam logic [CNT_W-1:0] MAX_ON_LAST = MAX_ON - CNT_W'(1);

  logic [CNT_W-1:0] on_timer_q, on_timer_d;
  logic             fault_q, fault_d;
  logic             on_expired;

  assign on_expired = ((state_q == ST_ON_MIN) || (state_q == ST_ON)) &&
                      (on_timer_q == MAX_ON_LAST);

  always_comb begin
    on_timer_d = on_timer_q;
    if ((state_d == ST_ON_MIN) && (state_q != ST_ON_MIN)) begin
      on_timer_d = '0;
    end else if (((state_q == ST_ON_MIN) || (state_q == ST_ON)) &&
                 (on_timer_q != MAX_ON_LAST)) begin
      on_timer_d = on_timer_q + CNT_W'(1);
    end
    fault_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_timer_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      on_timer_q <= on_timer_d;
      fault_q    <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  logic unused_max_on;
  assign unused_max_on = ^MAX_ON;
  assign fault         = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    switch_count_d = switch_count_q;
    unique case (state_q)
      ST_OFF: begin
        if (req_db) begin
          state_d        = ST_ON_MIN;
          switch_count_d = sat_inc(switch_count_q);
        end
      end
      // A release seen during the minimum on-time is acted on only at expiry.
      ST_ON_MIN:  if (timer_q == MIN_ON_LAST) state_d = req_db ? ST_ON : ST_OFF_MIN;
      ST_ON:      if (!req_db) state_d = ST_OFF_MIN;
      ST_OFF_MIN: if (timer_q == MIN_OFF_LAST) state_d = ST_OFF;
`ifdef RELAY_MAX_ON_EN
      ST_LOCKOUT: if (!req_db) state_d = ST_OFF_MIN;
`endif
      default:    state_d = ST_OFF;
    endcase
`ifdef RELAY_MAX_ON_EN
    // Max-on expiry overrides a coincident min-on expiry.
    if (on_expired) state_d = ST_LOCKOUT;
`endif
  end

  // Phase timer: cleared on every state change, saturates at the phase's terminal count.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (((state_q == ST_ON_MIN)  && (timer_q != MIN_ON_LAST)) ||
                 ((state_q == ST_OFF_MIN) && (timer_q != MIN_OFF_LAST))) begin
      timer_d = timer_q + CNT_W'(1);
    end
    relay_d = (state_d == ST_ON_MIN) || (state_d == ST_ON);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_OFF;
      timer_q        <= '0;
      switch_count_q <= '0;
      relay_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      switch_count_q <= switch_count_d;
      relay_q        <= relay_d;
    end
  end

  assign relay_control = relay_q;
  assign led_output    = relay_q;
  assign switch_count  = switch_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_relay_sequencer.sv
// Scoreboard bench for relay_sequencer: a countdown-based reference model
// predicts each cycle's outputs; a monitor compares them after every edge.
module tb_relay_sequencer;

  localparam int DEB   = 4;
  localparam int MON   = 10;
  localparam int MOFF  = 8;
  localparam int MAXON = 40;
`ifdef RELAY_MAX_ON_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  localparam int M_OFF = 0, M_ON_MIN = 1, M_ON = 2, M_OFF_MIN = 3, M_LOCK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_in = 1'b0;
  logic        relay_control, led_output, fault;
  logic [15:0] switch_count;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  relay_sequencer #(
    .CNT_W      (32),
    .DEB_CYCLES (32'd4),
    .MIN_ON     (32'd10),
    .MIN_OFF    (32'd8),
    .MAX_ON     (32'd40)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_in        (req_in),
    .relay_control (relay_control),
    .led_output    (led_output),
    .fault         (fault),
    .switch_count  (switch_count),
    .state_o       (state_o)
  );

  typedef struct packed {
    logic        relay;
    logic        led;
    logic        fault;
    logic [15:0] cnt;
    logic [2:0]  st;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic seen_relay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: pipeline of raw samples, run-length of disagreement,
  // and the sequencer as a phase with remaining-cycle countdowns.
  logic        m_s1, m_s2, m_db;
  int          m_run, m_mode, m_left, m_on_left;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
    m_mode = M_OFF; m_left = 0; m_on_left = 0; m_cnt = 16'h0;
  endtask

  task automatic model_step(input logic r);
    logic db_old;
    db_old = m_db;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DEB) begin
        m_db  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = r;
    case (m_mode)
      M_OFF: if (db_old) begin
        m_mode = M_ON_MIN; m_left = MON; m_on_left = MAXON;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      end
      M_ON_MIN: begin
        m_left--; m_on_left--;
        if (MAX_EN && m_on_left == 0) m_mode = M_LOCK;
        else if (m_left == 0) begin
          if (db_old) m_mode = M_ON;
          else begin m_mode = M_OFF_MIN; m_left = MOFF; end
        end
      end
      M_ON: begin
        m_on_left--;
        if (MAX_EN && m_on_left == 0) m_mode = M_LOCK;
        else if (!db_old) begin m_mode = M_OFF_MIN; m_left = MOFF; end
      end
      M_OFF_MIN: begin
        m_left--;
        if (m_left == 0) m_mode = M_OFF;
      end
      default: if (!db_old) begin m_mode = M_OFF_MIN; m_left = MOFF; end
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.relay = (m_mode == M_ON_MIN) || (m_mode == M_ON);
    o.led   = o.relay;
    o.fault = (m_mode == M_LOCK);
    o.cnt   = m_cnt;
    o.st    = 3'(m_mode);
    return o;
  endfunction

  task automatic drive_now(input logic r);
    req_in = r;
    model_step(r);
    exp_q.push_back(model_obs());
  endtask

  task automatic tick(input logic r);
    @(negedge clk);
    seen_relay = relay_control;
    drive_now(r);
  endtask

  // Monitor: one expected observation per modelled edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{relay: relay_control, led: led_output, fault: fault, cnt: switch_count, st: state_o};
      check($sformatf("cycle %0d outputs", cyc), 32'(a), 32'(e));
    end
    cyc++;
  end

  initial begin
    int   k;
    logic lvl;
    logic glitch_on;

    model_reset();
    #12;
    check("reset relay", 32'(relay_control), 32'd0);
    check("reset led", 32'(led_output), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset count", 32'(switch_count), 32'd0);
    check("reset state", 32'(state_o), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive_now(1'b0);
    repeat (5) tick(1'b0);

    // Rising request: relay follows after DEB+3 edges.
    tick(1'b1);
    k = 0;
    do begin tick(1'b1); k++; end while (!seen_relay && k < 30);
    check("on latency", 32'(k), 32'd7);
    check("first on count", 32'(switch_count), 32'd1);
    check("first on state", 32'(state_o), 32'd1);
    check("first on led", 32'(led_output), 32'd1);
    repeat (12) tick(1'b1);

    // Asynchronous reset while on, request still held.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset relay", 32'(relay_control), 32'd0);
    check("async reset led", 32'(led_output), 32'd0);
    check("async reset count", 32'(switch_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_now(1'b1);
    k = 0;
    do begin tick(1'b1); k++; end while (!seen_relay && k < 30);
    check("post reset latency", 32'(k), 32'd7);

    // Short glitch from OFF is rejected.
    repeat (40) tick(1'b0);
    glitch_on = 1'b0;
    repeat (3) begin tick(1'b1); glitch_on |= seen_relay; end
    repeat (20) begin tick(1'b0); glitch_on |= seen_relay; end
    check("glitch relay", 32'(glitch_on), 32'd0);
    check("glitch count", 32'(switch_count), 32'd1);

    // Long hold: lockout with the max-on feature, stays on without it.
    repeat (60) tick(1'b1);
    check("long hold fault", 32'(fault), 32'(MAX_EN));
    check("long hold state", 32'(state_o), MAX_EN ? 32'd4 : 32'd2);
    check("long hold relay", 32'(relay_control), MAX_EN ? 32'd0 : 32'd1);
    repeat (30) tick(1'b0);

    // Saturation: preload the counter just below its ceiling.
    repeat (3) tick(1'b1);
    @(negedge clk);
    force dut.switch_count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    drive_now(1'b0);
    @(negedge clk);
    release dut.switch_count_q;
    drive_now(1'b0);
    repeat (40) tick(1'b0);
    repeat (30) tick(1'b1);
    check("count reaches max", 32'(switch_count), 32'hFFFF);
    repeat (40) tick(1'b0);
    repeat (30) tick(1'b1);
    check("count saturates", 32'(switch_count), 32'hFFFF);

    // Randomized segments mixing glitches, boundary-length pulses and long holds.
    lvl = 1'b1;
    for (int s = 0; s < 60; s++) begin
      int len;
      lvl = ~lvl;
      if ($urandom_range(0, 1) == 0) len = $urandom_range(1, DEB + 1);
      else len = $urandom_range(DEB + 2, 70);
      repeat (len) tick(lvl);
    end
    repeat (40) tick(1'b0);

    @(posedge clk);
    #2;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relay_sequencer.md
Name: relay_sequencer

Overview:
- Upstream control stage for the relay driver: converts a noisy sensor/button request into a clean, rate-limited relay command.
- Synchronises and debounces `req_in`, then enforces minimum on-time and minimum off-time (anti-chatter).
- Optionally enforces a maximum on-time with a fault lockout.
- Drives `relay_control` and `led_output` directly; these replace free-running toggling in sensor-driven builds.

Parameters:
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a `req_in` change (10 ms at 100 MHz); must be >= 1
- MIN_ON, 50000000, minimum cycles the relay stays on once switched on; must be >= 1
- MIN_OFF, 50000000, minimum cycles the relay stays off once switched off; must be >= 1
- MAX_ON, 3000000000, maximum continuous on-cycles, used only with RELAY_MAX_ON_EN; must be > MIN_ON
- CNT_W, 32, width of all internal timers

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- req_in  in  1  raw asynchronous request from sensor/button; 1 = relay wanted on
- relay_control  out  1  relay drive; 1 = energised
- led_output  out  1  board LED; mirrors `relay_control`
- fault  out  1  max-on lockout active; constant 0 without macro
- switch_count  out  16  number of off-to-on relay transitions, saturating at 16'hFFFF
- state_o  out  3  current FSM state encoding, for debug

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Reset assertion immediately forces:
  - `relay_control`=0, `led_output`=0, `fault`=0, `switch_count`=0
  - state=OFF, all timers 0, sync flops 0, debounced request `req_db`=0
- Synchroniser: `req_in` passes through 2 flops to give `req_s`.
- Debounce:
  - Counter increments while `req_s` != `req_db`; clears on any cycle where they are equal.
  - When the counter reaches DEB_CYCLES-1 with a mismatch, `req_db` takes `req_s` and the counter clears.
  - Pulses shorter than DEB_CYCLES cycles are rejected.
- Latency: a `req_in` change appears at `req_db` DEB_CYCLES+2 edges later. All outputs are registered, so `relay_control` follows one edge after the FSM transition (DEB_CYCLES+3 total from OFF).
- FSM states:
  - OFF: relay 0. If `req_db`=1, go to ON_MIN, clear timers, increment `switch_count` (saturating).
  - ON_MIN: relay 1; timer counts. At timer==MIN_ON-1, go to ON if `req_db`=1, else OFF_MIN. A release during ON_MIN is honoured only at expiry.
  - ON: relay 1. If `req_db`=0, go to OFF_MIN with timer cleared.
  - OFF_MIN: relay 0; timer counts. At timer==MIN_OFF-1, go to OFF. Requests are ignored in this state; if `req_db` is still 1 on reaching OFF, ON_MIN is entered the next cycle.
  - LOCKOUT (macro only): relay 0, `fault`=1. If `req_db`=0, go to OFF_MIN and `fault` clears on that transition.
- Encoding: OFF=0, ON_MIN=1, ON=2, OFF_MIN=3, LOCKOUT=4.
- `led_output` always equals `relay_control` in the same cycle.
- Timers never wrap: each clears on state entry and stops at its terminal value.
- Reset mid-ON: relay drops the cycle reset asserts. After release with `req_in` held high, the relay re-energises after DEB_CYCLES+3 edges; the min-off time is not enforced after reset.

Optional Feature:
- Macro: RELAY_MAX_ON_EN.
- Defined:
  - A separate on-timer runs in ON_MIN and ON and clears on entering ON_MIN.
  - At on-timer==MAX_ON-1 the FSM goes to LOCKOUT from either state.
  - If this coincides with MIN_ON expiry, LOCKOUT has priority.
- Undefined:
  - No on-timer, no LOCKOUT state logic.
  - `fault` is tied 0; MAX_ON is ignored.

Decomposition:
- Package relay_pkg holds:
  - state encodings (OFF/ON_MIN/ON/OFF_MIN/LOCKOUT, 3-bit)
  - default CNT_W
  - SWITCH_CNT_W=16
- Sub-module relay_debounce, instantiated once:
  - parameters DEB_CYCLES, CNT_W
  - ports clk, rst_n, `din`, `dout`
  - contains the 2-flop synchroniser plus the stability counter

Test Plan (DEB_CYCLES=4, MIN_ON=10, MIN_OFF=8, MAX_ON=40):
- `req_in` 0→1 held: `relay_control`=1 exactly 7 edges later; `led_output` equal; `switch_count`=1; `state_o`=1, then 2 after 10 more cycles.
- 3-cycle `req_in` glitch high from OFF: `req_db` never rises; `relay_control` stays 0; `switch_count` 0.
- Request high, then released 2 cycles after relay on: relay stays 1 until ON_MIN expires (10 cycles), then 0. Re-request during OFF_MIN: relay stays 0 for 8 cycles, re-energises 1 edge after OFF, `switch_count`=2.
- `rst_n` pulsed low while ON: `relay_control`, `led_output`, `switch_count` go 0 without a clock edge. After release with `req_in` high, relay on 7 edges later.
- RELAY_MAX_ON_EN defined, request held 60 cycles: relay drops after 40 on-cycles; `fault`=1, `state_o`=4. Release `req_in`: `fault` clears, `state_o`=3, then 0 after 8 cycles. Macro undefined: relay stays 1 and `fault`=0 throughout.
- Force 65535 transitions (or preload via hierarchical force): `switch_count` holds 16'hFFFF on the next on-transition.
